// File: rtl/ifetch_queue.sv
`default_nettype none
// ifetch_queue: sequential instruction fetcher filling a DEPTH-entry FIFO toward decode.
// Rev 1.0 -- initial release
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4,
  parameter int          IM_WORDS = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [31:0]              im_addr,
  input  logic [31:0]              im_rd,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  input  logic                     out_ready,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL     = DEPTH[PW:0];
  // 33-bit window bounds so the top address cannot overflow for windows near 2^32
  localparam logic [32:0] WIN_LO   = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_SPAN = 33'(IM_WORDS) << 2;
  localparam logic [32:0] WIN_HI   = WIN_LO + WIN_SPAN - 33'd4;

  logic [31:0]   pc;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   ins_q [DEPTH];

  logic [32:0]   pc_ext;
  logic          push;
  logic          pop;

  assign pc_ext  = {1'b0, pc};
  assign fault   = (pc[1:0] != 2'b00) || (pc_ext < WIN_LO) || (pc_ext > WIN_HI);
  assign im_addr = pc;

  assign out_valid = (level != '0);
  assign out_pc    = pc_q[head];
  assign out_instr = ins_q[head];

  assign pop  = out_valid && out_ready;
  assign push = !redirect && !fault && ((level < FULL) || pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      level <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (redirect) begin
      // A same-cycle pop is dropped along with the rest of the queue
      pc    <= redirect_pc;
      head  <= '0;
      tail  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        pc_q[tail]  <= pc;
        ins_q[tail] <= im_rd;
        tail        <= tail + 1'b1;
        pc          <= pc + 32'd4;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// tb_ifetch_queue: directed stimulus with a scoreboard of expected head PCs drained by a monitor.
module tb_ifetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] im_addr;
  logic [31:0] im_rd;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;
  int mon_cnt = 0;
  logic [31:0] sb [$];

  ifetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .im_addr     (im_addr),
    .im_rd       (im_rd),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_ready   (out_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fault       (fault),
    .level       (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] im_fn(input logic [31:0] a);
    case (a)
      32'h0000_3000: return 32'h1111_1111;
      32'h0000_3004: return 32'h2222_2222;
      default:       return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  always_comb im_rd = im_fn(im_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the next scoreboard entry
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset && out_valid && out_ready) begin
      total++;
      mon_cnt++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got pc=%h, required no pop", out_pc);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e || out_instr !== im_fn(e)) begin
          bad++;
          $display("FAIL pop_data: got pc=%h instr=%h, required pc=%h instr=%h",
                   out_pc, out_instr, e, im_fn(e));
        end
      end
    end
  end

  initial begin
    reset = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_out_pc", out_pc, 32'h0);

    // Phase A: first two fetches after release
    sb.push_back(32'h3000); sb.push_back(32'h3004);
    reset = 1'b1; out_ready = 1'b1;
    step();
    chk("a_pc0", out_pc, 32'h3000);
    chk("a_ins0", out_instr, 32'h1111_1111);
    chk("a_lvl0", 32'(level), 32'd1);
    step();
    chk("a_pc1", out_pc, 32'h3004);
    chk("a_ins1", out_instr, 32'h2222_2222);
    step();
    out_ready = 1'b0;
    step();
    chk("a_lvl_pre_rst", 32'(level), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_level", 32'(level), 32'd0);
    chk("async_addr", im_addr, 32'h3000);

    // Phase B: fill with decode stalled, then stream at full occupancy
    @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) sb.push_back(32'h3000 + 32'(4 * k));
    reset = 1'b1;
    repeat (4) step();
    chk("b_full_lvl", 32'(level), 32'd4);
    chk("b_full_addr", im_addr, 32'h3010);
    repeat (2) step();
    chk("b_hold_lvl", 32'(level), 32'd4);
    chk("b_hold_addr", im_addr, 32'h3010);
    chk("b_hold_head", out_pc, 32'h3000);
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("b_stream_lvl", 32'(level), 32'd4);
      chk("b_stream_pc", out_pc, 32'h3000 + 32'(4 * k));
      chk("b_stream_addr", im_addr, 32'h3010 + 32'(4 * k));
    end

    // Phase C: redirect with a partially filled queue
    redirect = 1'b1; redirect_pc = 32'h3200; out_ready = 1'b0;
    step();
    chk("c_flush_lvl", 32'(level), 32'd0);
    chk("c_flush_addr", im_addr, 32'h3200);
    redirect = 1'b0;
    repeat (3) step();
    chk("c_lvl3", 32'(level), 32'd3);
    chk("c_addr3", im_addr, 32'h320C);
    redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    chk("c_redir_lvl", 32'(level), 32'd0);
    chk("c_redir_valid", 32'(out_valid), 32'd0);
    chk("c_redir_addr", im_addr, 32'h3100);
    redirect = 1'b0; out_ready = 1'b1;
    sb.push_back(32'h3100);
    step();
    chk("c_first_valid", 32'(out_valid), 32'd1);
    chk("c_first_pc", out_pc, 32'h3100);
    step();

    // Phase D: faulting redirects
    redirect = 1'b1; redirect_pc = 32'h3002; out_ready = 1'b0;
    step();
    redirect = 1'b0;
    chk("d_mis_fault", 32'(fault), 32'd1);
    chk("d_mis_lvl", 32'(level), 32'd0);
    repeat (2) step();
    chk("d_mis_lvl2", 32'(level), 32'd0);
    chk("d_mis_addr", im_addr, 32'h3002);
    redirect = 1'b1; redirect_pc = 32'h4000;
    step();
    redirect = 1'b0;
    repeat (2) step();
    chk("d_hi_fault", 32'(fault), 32'd1);
    chk("d_hi_lvl", 32'(level), 32'd0);
    chk("d_hi_addr", im_addr, 32'h4000);
    redirect = 1'b1; redirect_pc = 32'h2FFC;
    step();
    redirect = 1'b0;
    step();
    chk("d_lo_fault", 32'(fault), 32'd1);
    chk("d_lo_lvl", 32'(level), 32'd0);
    redirect = 1'b1; redirect_pc = 32'h3000;
    step();
    chk("d_ok_fault", 32'(fault), 32'd0);
    chk("d_ok_addr", im_addr, 32'h3000);
    redirect = 1'b0; out_ready = 1'b1;
    sb.push_back(32'h3000); sb.push_back(32'h3004);
    step();
    chk("d_resume_pc", out_pc, 32'h3000);
    chk("d_resume_lvl", 32'(level), 32'd1);
    step();
    chk("d_resume_pc2", out_pc, 32'h3004);
    // Pop coinciding with redirect
    redirect = 1'b1; redirect_pc = 32'h3FF4;
    step();
    chk("e_redir_lvl", 32'(level), 32'd0);
    chk("e_redir_valid", 32'(out_valid), 32'd0);
    chk("e_redir_addr", im_addr, 32'h3FF4);
    redirect = 1'b0; out_ready = 1'b0;

    // Phase E: run off the top of the window
    repeat (3) step();
    chk("e_top_lvl", 32'(level), 32'd3);
    chk("e_top_addr", im_addr, 32'h4000);
    chk("e_top_fault", 32'(fault), 32'd1);
    step();
    chk("e_nopush_lvl", 32'(level), 32'd3);
    chk("e_nopush_addr", im_addr, 32'h4000);
    sb.push_back(32'h3FF4); sb.push_back(32'h3FF8); sb.push_back(32'h3FFC);
    out_ready = 1'b1;
    repeat (3) step();
    chk("e_drain_lvl", 32'(level), 32'd0);
    chk("e_drain_valid", 32'(out_valid), 32'd0);
    chk("e_drain_fault", 32'(fault), 32'd1);
    step();
    chk("mon_pops", 32'(mon_cnt), 32'd14);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, SHALL be the first fetch address after reset.
REQ-002 Parameter DEPTH, default 4, SHALL be the queue entry count (power of two, >=2).
REQ-003 Parameter IM_WORDS, default 1024, SHALL be the instruction memory size in words; the valid window is [RESET_PC, RESET_PC+4*IM_WORDS-4].
REQ-004 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 im_addr  output  32  SHALL be the byte address driven to the combinational instruction memory.
REQ-007 im_rd  input  32  SHALL be the instruction word returned for im_addr in the same cycle.
REQ-008 out_valid  output  1  SHALL indicate the queue head is valid.
REQ-009 out_instr  output  32  SHALL be the head instruction word.
REQ-010 out_pc  output  32  SHALL be the head instruction's byte address.
REQ-011 out_ready  input  1  SHALL indicate the decode stage accepts the head this cycle.
REQ-012 redirect  input  1  SHALL request a flush and refetch from redirect_pc.
REQ-013 redirect_pc  input  32  SHALL be the new fetch address, sampled when redirect=1.
REQ-014 fault  output  1  SHALL flag that the fetch PC is misaligned or outside the valid window.
REQ-015 level  output  $clog2(DEPTH)+1  SHALL report the current queue occupancy.

Function
REQ-016 im_addr SHALL equal the internal fetch PC register combinationally.
REQ-017 fault SHALL be 1 exactly when pc[1:0]!=0 or pc is outside the valid window; purely decoded from the PC register.
REQ-018 pop SHALL occur when out_valid=1 and out_ready=1.
REQ-019 push SHALL occur when redirect=0, fault=0, and (level<DEPTH or pop); it writes {pc, im_rd} at the tail and advances pc by 4.
REQ-020 Full queue with simultaneous pop SHALL push and pop in the same cycle; level unchanged.
REQ-021 Full queue without pop SHALL hold pc and queue contents; no push.
REQ-022 Empty queue SHALL drive out_valid=0; out_instr/out_pc are don't-care but SHALL not be X after reset (hold last value or zero).
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-024 redirect=1 SHALL, at the next edge, set level=0, reset both pointers, load pc=redirect_pc, and suppress any push; a pop in the same cycle is considered consumed but has no further effect.
REQ-025 First push after redirect SHALL occur on the cycle following redirect, using im_rd for redirect_pc (if valid).
REQ-026 While fault=1, no pushes SHALL occur; queued entries SHALL still drain normally; fault clears only via redirect to a valid address.
REQ-027 pc+4 SHALL be 32-bit modulo; advancing past the window top SHALL raise fault on the next cycle, not wrap into the window.
REQ-028 Latency: instruction at address A SHALL appear at out_* one cycle after pc=A when the queue is empty.

Reset
REQ-029 reset=0 SHALL asynchronously set pc=RESET_PC, level=0, pointers=0, out_valid=0, fault=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; the first push after release uses RESET_PC.
REQ-031 Reset deassertion SHALL be the only timing dependency; the first push occurs on the first rising edge with reset=1.

Verification
REQ-032 Release reset, out_ready=1, IM holds 0x11111111 at 0x3000 and 0x22222222 at 0x3004 -> cycle 1 out_pc=0x3000/instr=0x11111111, cycle 2 out_pc=0x3004/instr=0x22222222.
REQ-033 out_ready=0 for 6 cycles after reset -> level reaches 4 after 4 cycles, im_addr holds 0x3010; then out_ready=1 -> entries 0x3000..0x300C drain in order, no loss or duplication.
REQ-034 Queue full, out_ready=1 held -> one push and one pop per cycle, level stays 4, out_pc advances by 4 each cycle.
REQ-035 redirect=1, redirect_pc=0x3100 with level=3 -> next cycle level=0, out_valid=0, im_addr=0x3100; following cycle out_pc=0x3100.
REQ-036 redirect_pc=0x3002, then redirect_pc=0x4000 -> fault=1, no pushes, level stays 0 in each case; redirect to 0x3000 -> fault=0, fetching resumes.
REQ-037 Fetch reaching 0x3FFC -> 0x3FFC pushed, pc=0x4000, fault=1, no further pushes; queued entries drain.
REQ-038 reset=0 asserted asynchronously between edges with level=2 -> out_valid=0 immediately, im_addr=0x3000.
